// File: rtl/geo_pkg.sv
// Shared definitions for the geometric-forms line buffer path.
// Holds line geometry, the 3/3/3 colour type and the line-writer state enum.
package geo_pkg;

    localparam int LINE_PIXELS = 640;
    localparam int ADDR_W      = 10;
    localparam int COLOR_W     = 9;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [2:0] b;
    } color_t;

    // Debug taps decode the writer state through this enum, so keep the encoding stable.
    typedef enum logic [1:0] {
        STREAM = 2'd0,
        FILL   = 2'd1,
        DONE   = 2'd2
    } writer_state_e;

endpackage

// File: rtl/pixel_line_writer.sv
// Line-memory write-port controller: streams comparator pixels into consecutive
// addresses and back-fills the rest of the line with BG_COLOR after a flush.
module pixel_line_writer #(
    parameter int                       LINE_PIXELS = geo_pkg::LINE_PIXELS,
    parameter int                       ADDR_W      = geo_pkg::ADDR_W,
    parameter int                       COLOR_W     = geo_pkg::COLOR_W,
    parameter logic [COLOR_W-1:0]       BG_COLOR    = '0
) (
    input  logic                clk,
    input  logic                reset_counter,
    input  logic                in_valid,
    input  logic [COLOR_W-1:0]  in_color,
    input  logic                flush,
    output logic                mem_wren,
    output logic [ADDR_W-1:0]   mem_wraddress,
    output logic [COLOR_W-1:0]  mem_data,
    output logic                line_done,
    output logic                overflow,
    output logic [ADDR_W-1:0]   pixel_count
);
    import geo_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_PIXELS - 1);

    logic [1:0]          rst_sync;
    logic                run;
    writer_state_e       state, state_nxt;
    logic [ADDR_W-1:0]   wr_ptr, wr_ptr_nxt;
    logic [ADDR_W-1:0]   pixel_count_nxt;
    logic [ADDR_W-1:0]   addr_nxt;
    logic [COLOR_W-1:0]  data_nxt;
    logic                wren_nxt;
    logic                overflow_nxt;

    // Assertion is immediate; release takes two clk edges so the FSM starts cleanly.
    always_ff @(posedge clk or negedge reset_counter) begin
        if (!reset_counter) rst_sync <= '0;
        else                rst_sync <= {rst_sync[0], 1'b1};
    end

    assign run = rst_sync[1];

    always_comb begin
        state_nxt       = state;
        wr_ptr_nxt      = wr_ptr;
        pixel_count_nxt = pixel_count;
        wren_nxt        = 1'b0;
        addr_nxt        = mem_wraddress;
        data_nxt        = mem_data;
        overflow_nxt    = overflow;

        unique case (state)
            STREAM: begin
                if (in_valid) begin
                    wren_nxt        = 1'b1;
                    addr_nxt        = wr_ptr;
                    data_nxt        = in_color;
                    wr_ptr_nxt      = wr_ptr + 1'b1;
                    pixel_count_nxt = pixel_count + 1'b1;
                end
                // A pixel arriving with the flush is written first; the fill then starts at the next address.
                if (in_valid && wr_ptr == LAST_ADDR) state_nxt = DONE;
                else if (flush)                      state_nxt = FILL;
            end
            FILL: begin
                wren_nxt   = 1'b1;
                addr_nxt   = wr_ptr;
                data_nxt   = BG_COLOR;
                wr_ptr_nxt = wr_ptr + 1'b1;
                if (wr_ptr == LAST_ADDR) state_nxt    = DONE;
                if (in_valid)            overflow_nxt = 1'b1;
            end
            DONE: begin
                if (in_valid) overflow_nxt = 1'b1;
            end
            default: state_nxt = STREAM;
        endcase
    end

    always_ff @(posedge clk or negedge reset_counter) begin
        if (!reset_counter) begin
            state         <= STREAM;
            wr_ptr        <= '0;
            pixel_count   <= '0;
            mem_wren      <= 1'b0;
            mem_wraddress <= '0;
            mem_data      <= '0;
            line_done     <= 1'b0;
            overflow      <= 1'b0;
        end else if (run) begin
            state         <= state_nxt;
            wr_ptr        <= wr_ptr_nxt;
            pixel_count   <= pixel_count_nxt;
            mem_wren      <= wren_nxt;
            mem_wraddress <= addr_nxt;
            mem_data      <= data_nxt;
            line_done     <= (state == DONE);
            overflow      <= overflow_nxt;
        end
    end

endmodule

// File: tb/tb_pixel_line_writer.sv
// Randomised scoreboard bench for pixel_line_writer: a line-level model queues
// the expected memory writes and a negedge monitor checks each presented write.
module tb_pixel_line_writer;
    import geo_pkg::*;

    localparam logic [8:0] BG = 9'h0A5;

    logic        clk = 1'b0;
    logic        reset_counter;
    logic        in_valid;
    logic [8:0]  in_color;
    logic        flush;
    logic        mem_wren;
    logic [9:0]  mem_wraddress;
    logic [8:0]  mem_data;
    logic        line_done;
    logic        overflow;
    logic [9:0]  pixel_count;

    int          errors = 0;
    int          checks = 0;
    int          line_writes = 0;
    bit          ld_pending = 0;
    logic [18:0] exp_q[$];

    pixel_line_writer #(.BG_COLOR(BG)) dut (
        .clk           (clk),
        .reset_counter (reset_counter),
        .in_valid      (in_valid),
        .in_color      (in_color),
        .flush         (flush),
        .mem_wren      (mem_wren),
        .mem_wraddress (mem_wraddress),
        .mem_data      (mem_data),
        .line_done     (line_done),
        .overflow      (overflow),
        .pixel_count   (pixel_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Line model: everything from address n upward becomes background.
    task automatic push_fill(input int n);
        for (int a = n; a < LINE_PIXELS; a++) exp_q.push_back({10'(a), BG});
    endtask

    always @(negedge clk) begin
        logic [18:0] e;
        if (ld_pending) begin
            chk("line_done_rise", {31'd0, line_done}, 32'd1);
            ld_pending = 0;
        end
        if (mem_wren) begin
            line_writes++;
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {22'd0, mem_wraddress}, 32'h3FF);
            end else begin
                e = exp_q.pop_front();
                chk("write_addr_data", {13'd0, mem_wraddress, mem_data}, {13'd0, e});
            end
            if (mem_wraddress == 10'(LINE_PIXELS - 1)) begin
                chk("line_done_early", {31'd0, line_done}, 32'd0);
                ld_pending = 1;
            end
        end
    end

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_wren"},  {31'd0, mem_wren},      32'd0);
        chk({tag, "_addr"},  {22'd0, mem_wraddress}, 32'd0);
        chk({tag, "_data"},  {23'd0, mem_data},      32'd0);
        chk({tag, "_done"},  {31'd0, line_done},     32'd0);
        chk({tag, "_ovf"},   {31'd0, overflow},      32'd0);
        chk({tag, "_count"}, {22'd0, pixel_count},   32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        reset_counter = 1'b0;
        in_valid      = 1'b0;
        flush         = 1'b0;
        #1;
        chk_outputs_zero("reset");
        exp_q.delete();
        ld_pending  = 0;
        line_writes = 0;
        @(posedge clk);
        #2 reset_counter = 1'b1;
        repeat (3) @(posedge clk);
    endtask

    // One line: n stream pixels, then a flush either with the last pixel or flush_gap idle cycles later.
    task automatic run_line(input int n, input bit sim_flush, input int flush_gap,
                            input bit gaps, input bit extra, input bit rand_col, input bit force_last);
        int         sent    = 0;
        bit         ended   = 0;
        bit         exp_ovf = 0;
        logic [8:0] c;
        while (sent < n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            flush    = 1'b0;
            if (gaps && $urandom_range(3) == 0) continue;
            c = rand_col ? 9'($urandom) : 9'(sent);
            if (force_last && sent == n - 1) c = 9'h1FF;
            in_valid = 1'b1;
            in_color = c;
            exp_q.push_back({10'(sent), c});
            sent++;
            if (sent == n && sim_flush && n < LINE_PIXELS) begin
                flush = 1'b1;
                push_fill(n);
                ended = 1;
            end
        end
        if (n == LINE_PIXELS) ended = 1;
        if (!ended) begin
            for (int i = 0; i < flush_gap; i++) begin
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                flush    = 1'b0;
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            flush    = 1'b1;
            push_fill(n);
        end
        for (int w = 0; w < 1000; w++) begin
            @(posedge clk);
            #1;
            flush    = 1'b0;
            in_valid = extra && ($urandom_range(1) == 1);
            in_color = 9'($urandom);
            if (in_valid) exp_ovf = 1;
            if (line_done) break;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("line_done",   {31'd0, line_done},   32'd1);
        chk("pixel_count", {22'd0, pixel_count}, 32'(n));
        chk("overflow",    {31'd0, overflow},    {31'd0, exp_ovf});
        chk("queue_empty", 32'(exp_q.size()),    32'd0);
        chk("line_writes", 32'(line_writes),     32'(LINE_PIXELS));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  reached;
        reset_counter = 1'b0;
        in_valid      = 1'b0;
        in_color      = '0;
        flush         = 1'b0;
        #3;
        chk_outputs_zero("init");
        @(posedge clk);
        #2 reset_counter = 1'b1;
        repeat (3) @(posedge clk);

        run_line(640, 0, 0, 0, 0, 0, 0);   // full stream, colour = address
        do_reset();
        run_line(100, 0, 0, 0, 0, 1, 0);   // flush one cycle after pixel 100
        do_reset();
        run_line(50, 1, 0, 0, 0, 1, 1);    // flush together with 50th pixel 9'h1FF
        do_reset();
        run_line(20, 0, 2, 0, 1, 1, 0);    // in_valid during fill and after done
        do_reset();
        run_line(0, 0, 0, 0, 0, 1, 0);     // flush on an empty line
        do_reset();
        run_line(640, 0, 0, 1, 1, 1, 0);   // full line then overflow in DONE
        do_reset();

        // Reset mid-fill, then the next line must start at address 0.
        @(posedge clk);
        #1;
        flush = 1'b1;
        push_fill(0);
        @(posedge clk);
        #1;
        flush   = 1'b0;
        reached = 0;
        for (int w = 0; w < 1000; w++) begin
            @(posedge clk);
            if (line_writes >= 300) begin
                reached = 1;
                break;
            end
        end
        chk("midfill_reached", {31'd0, reached}, 32'd1);
        do_reset();
        run_line(1, 1, 0, 0, 0, 1, 0);

        for (int r = 0; r < 6; r++) begin
            do_reset();
            n = (r == 0) ? 639 : int'($urandom_range(0, 640));
            run_line(n, bit'($urandom_range(1)), int'($urandom_range(0, 5)),
                     bit'($urandom_range(1)), bit'($urandom_range(1)), 1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
